// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer: next-address select, return stack, ctrl gating
module micro_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int CTRL_W      = 22,
    parameter int NCOND       = 4,
    parameter int STACK_DEPTH = 2,
    parameter int RESET_ADDR  = 0,
    localparam int CSEL_W     = $clog2(NCOND),
    localparam int UW         = CTRL_W + 3 + CSEL_W + 1 + ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [NCOND-1:0]  cond,
    output logic [ADDR_W-1:0] uaddr,
    input  logic [UW-1:0]     uword,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              seq_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'd0,
        OP_JUMP     = 3'd1,
        OP_BRANCH   = 3'd2,
        OP_DISPATCH = 3'd3,
        OP_CALL     = 3'd4,
        OP_RET      = 3'd5,
        OP_WAIT     = 3'd6,
        OP_HALT     = 3'd7
    } op_e;

    op_e               op;
    logic [CSEL_W-1:0] csel;
    logic [CSEL_W-1:0] csel_inc;
    logic              pol;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] upc1;
    logic [ADDR_W-1:0] nxt_addr;
    logic              hit;
    logic              stk_full;
    logic              stk_empty;
    logic              do_push;
    logic              do_pop;
    logic              err_set;
    logic [SP_W-1:0]   sp;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic [ADDR_W-1:0] stack_mem [2**IDX_W];

    assign op       = op_e'(uword[UW-1 -: 3]);
    assign csel     = uword[CTRL_W+ADDR_W+1 +: CSEL_W];
    assign pol      = uword[CTRL_W+ADDR_W];
    assign target   = uword[CTRL_W +: ADDR_W];
    // NCOND is a power of two, so the wrap of csel+1 is plain truncation
    assign csel_inc = csel + CSEL_W'(1);
    assign upc1     = uaddr + ADDR_W'(1);
    assign hit      = (cond[csel] == pol);

    assign stk_full  = (sp == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp == '0);
    assign push_idx  = sp[IDX_W-1:0];
    assign pop_idx   = push_idx - IDX_W'(1);

    assign ctrl_out = (reset_n && !stall) ? uword[CTRL_W-1:0] : '0;

    always_comb begin
        nxt_addr = upc1;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        err_set  = 1'b0;
        case (op)
            OP_NEXT:     nxt_addr = upc1;
            OP_JUMP:     nxt_addr = target;
            OP_BRANCH:   nxt_addr = hit ? target : upc1;
            OP_DISPATCH: nxt_addr = {target[ADDR_W-1:2], cond[csel_inc], cond[csel]};
            OP_CALL: begin
                // an overflowing call still jumps; only the return address is lost
                nxt_addr = target;
                if (stk_full) begin
                    err_set = 1'b1;
                end else begin
                    do_push = 1'b1;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    nxt_addr = ADDR_W'(RESET_ADDR);
                    err_set  = 1'b1;
                end else begin
                    nxt_addr = stack_mem[pop_idx];
                    do_pop   = 1'b1;
                end
            end
            OP_WAIT:     nxt_addr = hit ? uaddr : upc1;
            OP_HALT:     nxt_addr = uaddr;
            default:     nxt_addr = upc1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uaddr   <= ADDR_W'(RESET_ADDR);
            sp      <= '0;
            seq_err <= 1'b0;
        end else if (!stall) begin
            uaddr <= nxt_addr;
            if (do_push) begin
                sp <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp - SP_W'(1);
            end
            if (err_set) begin
                seq_err <= 1'b1;
            end
        end
    end

    // Stack contents are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk) begin
        if (reset_n && !stall && do_push) begin
            stack_mem[push_idx] <= upc1;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [3:0]  cond;
    logic [3:0]  uaddr;
    logic [31:0] uword;
    logic [21:0] ctrl_out;
    logic        seq_err;
    logic [31:0] rom [16];
    int          total = 0;
    int          bad = 0;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRANCH = 3'd2, DISPATCH = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, WAITC = 3'd6, HALT = 3'd7;

    always #5 clk = ~clk;

    assign uword = rom[uaddr];

    micro_sequencer #(
        .ADDR_W(4), .CTRL_W(22), .NCOND(4), .STACK_DEPTH(2), .RESET_ADDR(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .cond(cond),
        .uaddr(uaddr),
        .uword(uword),
        .ctrl_out(ctrl_out),
        .seq_err(seq_err)
    );

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [1:0] cs,
                                       input logic p, input logic [3:0] t,
                                       input logic [21:0] c);
        return {op, cs, p, t, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_next();
        for (int i = 0; i < 16; i++) begin
            rom[i] = mk(NEXT, 2'd0, 1'b0, 4'd0, 22'(22'h3F000 + i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        cond    = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = $urandom;

        // 1: reset state and first sequential steps
        #12;
        chk("rst_uaddr", uaddr, 0);
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_err", seq_err, 0);
        fill_next();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_uaddr", uaddr, 0);
        chk("rel_ctrl", ctrl_out, 22'h3F000);
        step(); chk("next1", uaddr, 1);
        chk("next1_ctrl", ctrl_out, 22'h3F001);
        step(); chk("next2", uaddr, 2);
        step(); chk("next3", uaddr, 3);

        // 2: wrap and branch
        repeat (12) step();
        chk("at15", uaddr, 15);
        step(); chk("wrap", uaddr, 0);
        rom[0] = mk(BRANCH, 2'd1, 1'b1, 4'd9, 22'd0);
        cond = 4'b0010;
        step(); chk("br_taken", uaddr, 9);
        do_reset();
        cond = 4'b0000;
        step(); chk("br_not", uaddr, 1);

        // 3: dispatch sweep on cond[3:2], then csel wrap (cond[0] is the high bit)
        rom[0] = mk(DISPATCH, 2'd2, 1'b0, 4'b1000, 22'd0);
        for (int k = 0; k < 4; k++) begin
            do_reset();
            cond = {k[1:0], 2'b00};
            step(); chk("dispatch", uaddr, 8 + k);
        end
        rom[0] = mk(DISPATCH, 2'd3, 1'b0, 4'b1000, 22'd0);
        do_reset();
        cond = 4'b0001;
        step(); chk("disp_wrap", uaddr, 4'b1010);
        cond = 4'b0000;

        // 4: nested call/return
        fill_next();
        rom[3]  = mk(CALL, 2'd0, 1'b0, 4'd5, 22'd0);
        rom[5]  = mk(CALL, 2'd0, 1'b0, 4'd12, 22'd0);
        rom[12] = mk(RET, 2'd0, 1'b0, 4'd0, 22'd0);
        rom[6]  = mk(RET, 2'd0, 1'b0, 4'd0, 22'd0);
        do_reset();
        repeat (3) step();
        chk("call_at3", uaddr, 3);
        step(); chk("call5", uaddr, 5);
        step(); chk("call12", uaddr, 12);
        step(); chk("ret6", uaddr, 6);
        step(); chk("ret4", uaddr, 4);
        chk("cr_err", seq_err, 0);

        // overflow: third nested call still jumps
        fill_next();
        rom[0] = mk(CALL, 2'd0, 1'b0, 4'd1, 22'd0);
        rom[1] = mk(CALL, 2'd0, 1'b0, 4'd2, 22'd0);
        rom[2] = mk(CALL, 2'd0, 1'b0, 4'd7, 22'd0);
        rom[7] = mk(HALT, 2'd0, 1'b0, 4'd0, 22'd0);
        do_reset();
        step(); chk("ov_c1", uaddr, 1);
        step(); chk("ov_c2", uaddr, 2);
        chk("ov_err0", seq_err, 0);
        step(); chk("ov_c3", uaddr, 7);
        chk("ov_err1", seq_err, 1);
        step(); chk("halt", uaddr, 7);

        // underflow: return on empty stack goes to reset address
        fill_next();
        rom[0] = mk(JUMP, 2'd0, 1'b0, 4'd6, 22'd0);
        rom[6] = mk(RET, 2'd0, 1'b0, 4'd0, 22'd0);
        do_reset();
        chk("un_clr", seq_err, 0);
        step(); chk("un_jump", uaddr, 6);
        step(); chk("un_ret", uaddr, 0);
        chk("un_err", seq_err, 1);
        step(); step();
        chk("un_sticky", seq_err, 1);

        // 5: wait on cond[0]==0, then release
        fill_next();
        rom[0] = mk(WAITC, 2'd0, 1'b0, 4'd0, 22'h00ABC);
        do_reset();
        cond = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step(); chk("wait_hold", uaddr, 0);
        end
        chk("wait_ctrl", ctrl_out, 22'h00ABC);
        cond = 4'b0001;
        step(); chk("wait_go", uaddr, 1);
        cond = 4'b0000;

        // stall over a CALL: no push, no advance, ctrl gated
        fill_next();
        rom[0] = mk(CALL, 2'd0, 1'b0, 4'd9, 22'h2AAAA);
        rom[9] = mk(RET, 2'd0, 1'b0, 4'd0, 22'd0);
        rom[1] = mk(RET, 2'd0, 1'b0, 4'd0, 22'd0);
        do_reset();
        stall = 1'b1;
        #1;
        chk("stall_ctrl", ctrl_out, 0);
        step(); step();
        chk("stall_hold", uaddr, 0);
        stall = 1'b0;
        #1;
        chk("unstall_ctrl", ctrl_out, 22'h2AAAA);
        step(); chk("st_call", uaddr, 9);
        step(); chk("st_ret", uaddr, 1);
        chk("st_err0", seq_err, 0);
        step(); chk("st_empty", uaddr, 0);
        chk("st_err1", seq_err, 1);

        // 6: reset between the two calls of a nest empties the stack
        fill_next();
        rom[0] = mk(CALL, 2'd0, 1'b0, 4'd4, 22'h11111);
        rom[4] = mk(CALL, 2'd0, 1'b0, 4'd8, 22'd0);
        do_reset();
        step(); chk("mid_c1", uaddr, 4);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_uaddr", uaddr, 0);
        chk("mid_err", seq_err, 0);
        chk("mid_ctrl", ctrl_out, 0);
        rom[0] = mk(RET, 2'd0, 1'b0, 4'd0, 22'd0);
        #2;
        reset_n = 1'b1;
        step(); chk("mid_ret", uaddr, 0);
        chk("mid_ret_err", seq_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
